// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream arbitration types, state codes and width helper
package stream_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_BUSY = ST_BUSY
   } arb_state_t;

   // Index width that never collapses to zero bits, so N=1 still has a grant port.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - requester/sink bundle for the packet round-robin arbiter
interface stream_rr_arbiter_if #(
   parameter int DW = 8,
   parameter int N  = 4
);
   localparam int GW = stream_pkg::clog2_min1(N);

   logic [N*DW-1:0] s_data_i;
   logic [N-1:0]    s_valid_i;
   logic [N-1:0]    s_last_i;
   logic [N-1:0]    s_ready_o;
   logic [DW-1:0]   m_data_o;
   logic            m_valid_o;
   logic            m_last_o;
   logic            m_ready_i;
   logic [GW-1:0]   grant_o;
   logic            busy_o;

   modport slave (
      input  s_data_i, s_valid_i, s_last_i, m_ready_i,
      output s_ready_o, m_data_o, m_valid_o, m_last_o, grant_o, busy_o
   );

   modport master (
      output s_data_i, s_valid_i, s_last_i, m_ready_i,
      input  s_ready_o, m_data_o, m_valid_o, m_last_o, grant_o, busy_o
   );

endinterface

// File: rtl/stream_rr_arbiter_rr_pick.sv
// rtl/stream_rr_arbiter_rr_pick.sv - round-robin picker: first set request after 'last', wrapping
module rr_pick #(
   parameter int N  = 4,
   parameter int GW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last,
   output logic          any,
   output logic [GW-1:0] idx
);

   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_rot;

   // Doubling the vector turns the wrap into a plain shift: bit j of w_rot is req[(last+1+j) % N].
   assign w_dbl = {req, req};
   assign w_rot = w_dbl >> (int'(last) + 1);

   always_comb begin
      any = |req;
      idx = '0;
      // Scan downward so the nearest request after 'last' is the final write.
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            idx = GW'((int'(last) + 1 + j) % N);
         end
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-granular round-robin arbiter of N streams onto one registered sink
module stream_rr_arbiter
   import stream_pkg::*;
#(
   parameter int DW = 8,
   parameter int N  = 4
) (
   input logic                clk,
   input logic                rst,
   stream_rr_arbiter_if.slave bus
);

   localparam int GW = clog2_min1(N);

   arb_state_t    r_state;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] r_last_grant;
   logic          r_busy;
   logic [DW-1:0] r_m_data;
   logic          r_m_valid;
   logic          r_m_last;

   logic          w_any;
   logic [GW-1:0] w_pick;
   logic          w_slot_rdy;
   logic          w_g_valid;
   logic          w_g_last;
   logic [DW-1:0] w_g_data;
   logic          w_accept;
   logic [N-1:0]  w_s_ready;

   rr_pick #(.N(N), .GW(GW)) u_pick (
      .req  (bus.s_valid_i),
      .last (r_last_grant),
      .any  (w_any),
      .idx  (w_pick)
   );

   // Output slot can take a beat if empty or draining this cycle; m_ready_i is the only comb input.
   assign w_slot_rdy = bus.m_ready_i || !r_m_valid;

   always_comb begin
      w_g_valid = 1'b0;
      w_g_last  = 1'b0;
      w_g_data  = '0;
      w_s_ready = '0;
      for (int k = 0; k < N; k++) begin
         if (GW'(k) == r_grant) begin
            w_g_valid    = bus.s_valid_i[k];
            w_g_last     = bus.s_last_i[k];
            w_g_data     = bus.s_data_i[k*DW +: DW];
            w_s_ready[k] = (r_state == S_BUSY) && w_slot_rdy;
         end
      end
   end

   assign w_accept = (r_state == S_BUSY) && w_g_valid && w_slot_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= '0;
         r_last_grant <= GW'(N - 1);
         r_busy       <= 1'b0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_m_data  <= w_g_data;
            r_m_last  <= w_g_last;
            r_m_valid <= 1'b1;
         end else if (bus.m_ready_i) begin
            r_m_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_busy  <= 1'b1;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_accept && w_g_last) begin
                  r_last_grant <= r_grant;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_ready_o = w_s_ready;
   assign bus.m_data_o  = r_m_data;
   assign bus.m_valid_o = r_m_valid;
   assign bus.m_last_o  = r_m_last;
   assign bus.grant_o   = r_grant;
   assign bus.busy_o    = r_busy;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - randomized and directed bench for stream_rr_arbiter against a cycle reference model
module tb_stream_rr_arbiter;

   localparam int DW = 8;
   localparam int N  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.DW(DW), .N(N)) bus ();
   stream_rr_arbiter #(.DW(DW), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_acc   = 0;

   bit [7:0] q_d[N][$];
   bit       q_l[N][$];
   bit       en[N];
   bit       rnd_en, rnd_mr, mr_fix, rst_req;

   bit       m_busy, m_ov, m_ol;
   bit [7:0] m_od;
   int       m_grant, m_last_grant;

   int       glog[$];
   int       acc_cyc[$];
   bit [7:0] snk_d[$];
   bit       snk_l[$];
   int       snk_cyc[$];
   bit       prev_busy;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_ov = 0; m_ol = 0; m_od = 0;
      m_grant = 0; m_last_grant = N - 1;
   endtask

   task automatic push_beat(input int p, input bit [7:0] d, input bit l);
      q_d[p].push_back(d);
      q_l[p].push_back(l);
   endtask

   function automatic bit all_empty();
      for (int p = 0; p < N; p++) if (q_d[p].size() != 0) return 0;
      return 1;
   endfunction

   task automatic step();
      logic [N-1:0]    vld, lst, exp_rdy;
      logic [N*DW-1:0] dat;
      bit mr, e, acc, found;
      int g, p;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         e = rnd_en ? ($urandom_range(0, 3) != 0) : en[k];
         vld[k] = (q_d[k].size() != 0) && e;
         dat[k*DW +: DW] = vld[k] ? q_d[k][0] : 8'($urandom);
         lst[k] = vld[k] ? q_l[k][0] : 1'($urandom);
      end
      mr = rnd_mr ? ($urandom_range(0, 2) != 0) : mr_fix;
      bus.s_valid_i = vld;
      bus.s_data_i  = dat;
      bus.s_last_i  = lst;
      bus.m_ready_i = mr;
      rst = rst_req;
      #1;
      exp_rdy = '0;
      if (m_busy) exp_rdy[m_grant] = mr || !m_ov;
      check_eq("s_ready", bus.s_ready_o, exp_rdy);
      check_eq("m_valid", bus.m_valid_o, m_ov);
      if (m_ov) begin
         check_eq("m_data", bus.m_data_o, m_od);
         check_eq("m_last", bus.m_last_o, m_ol);
      end
      check_eq("busy", bus.busy_o, m_busy);
      check_eq("grant", bus.grant_o, m_grant);
      if (bus.busy_o && !prev_busy) glog.push_back(int'(bus.grant_o));
      prev_busy = bus.busy_o;
      if (bus.m_valid_o && mr) begin
         snk_d.push_back(bus.m_data_o);
         snk_l.push_back(bus.m_last_o);
         snk_cyc.push_back(cyc);
      end
      if (rst_req) begin
         model_reset();
      end else begin
         g = m_grant;
         acc = m_busy && vld[g] && exp_rdy[g];
         if (acc) begin
            m_od = q_d[g].pop_front();
            m_ol = q_l[g].pop_front();
            m_ov = 1;
            acc_cyc.push_back(cyc);
            n_acc++;
         end else if (mr) begin
            m_ov = 0;
         end
         if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               p = (m_last_grant + k) % N;
               if (!found && vld[p]) begin
                  found = 1; m_grant = p; m_busy = 1;
               end
            end
         end else if (acc && m_ol) begin
            m_busy = 0;
            m_last_grant = g;
         end
      end
      cyc++;
   endtask

   task automatic run_until_idle(input string tag, input int budget);
      int n = 0;
      bit done = 0;
      while (!done && n < budget) begin
         step();
         n++;
         done = all_empty() && !m_busy && !m_ov;
      end
      check_eq({tag, "_drain"}, done, 1);
   endtask

   task automatic reset_dut();
      rst_req = 1; step(); rst_req = 0;
   endtask

   int exp_g[6] = '{0, 1, 3, 0, 1, 3};
   int c0, a0, s0, total;
   bit [7:0] held;

   initial begin
      rst = 1;
      bus.s_valid_i = '0; bus.s_data_i = '0; bus.s_last_i = '0; bus.m_ready_i = 1'b0;
      rnd_en = 0; rnd_mr = 0; mr_fix = 1; rst_req = 0;
      for (int p = 0; p < N; p++) en[p] = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
      prev_busy = 0;
      check_eq("rst_m_valid", bus.m_valid_o, 0);
      check_eq("rst_m_last", bus.m_last_o, 0);
      check_eq("rst_m_data", bus.m_data_o, 0);
      check_eq("rst_busy", bus.busy_o, 0);
      check_eq("rst_grant", bus.grant_o, 0);
      check_eq("rst_s_ready", bus.s_ready_o, 0);

      // Single source, 3-beat packet
      push_beat(0, 8'h11, 0); push_beat(0, 8'h22, 0); push_beat(0, 8'h33, 1);
      snk_d.delete(); snk_l.delete(); snk_cyc.delete();
      c0 = cyc;
      run_until_idle("single", 50);
      check_eq("single_cnt", snk_d.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("single_d%0d", i), snk_d[i], 8'h11 * (i + 1));
         check_eq($sformatf("single_l%0d", i), snk_l[i], (i == 2));
         check_eq($sformatf("single_cyc%0d", i), snk_cyc[i], c0 + 2 + i);
      end

      // Round-robin over ports 0,1,3 with two 2-beat packets each
      reset_dut();
      for (int k = 0; k < 2; k++)
         for (int p = 0; p < N; p++)
            if (p != 2)
               for (int b = 0; b < 2; b++) push_beat(p, 8'(p * 16 + k * 4 + b), (b == 1));
      glog.delete(); snk_d.delete(); snk_l.delete();
      run_until_idle("rr", 100);
      check_eq("rr_ngrant", glog.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("rr_grant%0d", i), glog[i], exp_g[i]);
         for (int b = 0; b < 2; b++)
            check_eq($sformatf("rr_beat%0d_%0d", i, b), snk_d[2*i+b], 8'(exp_g[i] * 16 + (i / 3) * 4 + b));
      end

      // Backpressure mid-packet
      for (int b = 0; b < 4; b++) push_beat(1, 8'hA0 + 8'(b), (b == 3));
      snk_d.delete(); snk_l.delete();
      a0 = n_acc;
      for (int i = 0; i < 20 && n_acc < a0 + 2; i++) step();
      check_eq("bp_reach", n_acc - a0, 2);
      mr_fix = 0;
      step();
      held = bus.m_data_o;
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("bp_hold", bus.m_data_o, held);
         check_eq("bp_ready_blk", bus.s_ready_o[1], 0);
      end
      mr_fix = 1;
      run_until_idle("bp", 50);
      check_eq("bp_cnt", snk_d.size(), 4);
      for (int b = 0; b < 4; b++) check_eq($sformatf("bp_d%0d", b), snk_d[b], 8'hA0 + 8'(b));

      // Granted source stalls while another port requests
      for (int b = 0; b < 4; b++) push_beat(0, 8'hB0 + 8'(b), (b == 3));
      snk_d.delete(); glog.delete();
      a0 = n_acc;
      for (int i = 0; i < 20 && n_acc < a0 + 2; i++) step();
      en[0] = 0;
      push_beat(2, 8'hC0, 0); push_beat(2, 8'hC1, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("stall_grant", bus.grant_o, 0);
         check_eq("stall_p2_ready", bus.s_ready_o[2], 0);
      end
      en[0] = 1;
      run_until_idle("stall", 60);
      check_eq("stall_cnt", snk_d.size(), 6);
      for (int b = 0; b < 4; b++) check_eq($sformatf("stall_d%0d", b), snk_d[b], 8'hB0 + 8'(b));
      check_eq("stall_d4", snk_d[4], 8'hC0);
      check_eq("stall_d5", snk_d[5], 8'hC1);
      check_eq("stall_order", glog[1], 2);

      // Reset mid-packet during beat 2 of 4
      for (int b = 0; b < 4; b++) push_beat(1, 8'hD0 + 8'(b), (b == 3));
      a0 = n_acc;
      for (int i = 0; i < 20 && n_acc < a0 + 1; i++) step();
      reset_dut();
      for (int p = 0; p < N; p++) begin q_d[p].delete(); q_l[p].delete(); end
      @(posedge clk); #1;
      check_eq("rmid_m_valid", bus.m_valid_o, 0);
      check_eq("rmid_busy", bus.busy_o, 0);
      check_eq("rmid_s_ready", bus.s_ready_o, 0);
      push_beat(3, 8'hE3, 1); push_beat(2, 8'hE2, 1);
      glog.delete();
      run_until_idle("rmid", 40);
      check_eq("rmid_first", glog[0], 2);

      // Wrap: last_grant=3, ports 0 and 3 send single-beat packets
      push_beat(3, 8'h5A, 1);
      run_until_idle("wrap_pre", 20);
      push_beat(0, 8'h01, 1); push_beat(3, 8'h03, 1);
      glog.delete(); acc_cyc.delete();
      c0 = cyc;
      run_until_idle("wrap", 20);
      check_eq("wrap_ngrant", glog.size(), 2);
      check_eq("wrap_g0", glog[0], 0);
      check_eq("wrap_g1", glog[1], 3);
      check_eq("wrap_acc0", acc_cyc[0], c0 + 1);
      check_eq("wrap_gap", acc_cyc[1] - acc_cyc[0], 2);

      // Randomized traffic, stalls and backpressure
      total = 0;
      s0 = snk_d.size();
      for (int p = 0; p < N; p++)
         for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) push_beat(p, 8'($urandom), (b == len - 1));
            total += len;
         end
      rnd_en = 1; rnd_mr = 1;
      run_until_idle("rand", 4000);
      rnd_en = 0; rnd_mr = 0;
      check_eq("rand_cnt", snk_d.size() - s0, total);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
